// File: rtl/digit_scan_ctrl.sv
// Multiplexed 7-segment scan controller: paced digit select, blanked
// active-low anodes, and per-digit / per-frame strobes.
module digit_scan_ctrl #(
    parameter int DIV          = 50000,
    parameter int NUM_DIGITS   = 8,
    parameter int BLANK_CYCLES = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       EN,
    output logic       S0,
    output logic       S1,
    output logic       S2,
    output logic [7:0] AN,
    output logic       TICK,
    output logic       FRAME
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [2:0]    IDX_LAST = 3'(NUM_DIGITS - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [2:0]    idx;
    logic [2:0]    idx_nxt;
    logic          slot_end;
    logic          wrap;
    logic          show;

    always_comb begin
        slot_end = EN && (cnt == CNT_LAST);
        wrap     = slot_end && (idx == IDX_LAST);
        cnt_nxt  = cnt;
        idx_nxt  = idx;
        if (!EN) begin
            cnt_nxt = '0;
        end else if (slot_end) begin
            cnt_nxt = '0;
            idx_nxt = wrap ? 3'd0 : idx + 3'd1;
        end else begin
            cnt_nxt = cnt + 1'b1;
        end
        // Anodes follow the next-state slot position so blanking
        // starts on the very edge the select changes.
        show = EN && (int'(cnt_nxt) >= BLANK_CYCLES);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt   <= '0;
            idx   <= 3'd0;
            AN    <= 8'hFF;
            TICK  <= 1'b0;
            FRAME <= 1'b0;
        end else begin
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            AN    <= show ? ~(8'b1 << idx_nxt) : 8'hFF;
            TICK  <= slot_end;
            FRAME <= wrap;
        end
    end

    assign {S2, S1, S0} = idx;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Bench for digit_scan_ctrl: three parameterisations checked against an
// arithmetic model of the scan (edges since enable -> slot, digit, phase).
module tb_digit_scan_ctrl;

    localparam int DIVS [3] = '{4, 2, 8};
    localparam int NS   [3] = '{6, 8, 8};
    localparam int BS   [3] = '{1, 0, 5};

    logic       clk;
    logic       rst_n;
    logic [2:0] en;
    logic [2:0] s    [3];
    logic [7:0] an   [3];
    logic [2:0] tick;
    logic [2:0] frame;

    int errors;
    int checks;

    // model: k = EN-high edges since the last restart, d0 = digit at restart
    int k  [3];
    int d0 [3];

    digit_scan_ctrl #(.DIV(4), .NUM_DIGITS(6), .BLANK_CYCLES(1)) u_a (
        .CLK(clk), .RST_N(rst_n), .EN(en[0]),
        .S0(s[0][0]), .S1(s[0][1]), .S2(s[0][2]),
        .AN(an[0]), .TICK(tick[0]), .FRAME(frame[0])
    );

    digit_scan_ctrl #(.DIV(2), .NUM_DIGITS(8), .BLANK_CYCLES(0)) u_b (
        .CLK(clk), .RST_N(rst_n), .EN(en[1]),
        .S0(s[1][0]), .S1(s[1][1]), .S2(s[1][2]),
        .AN(an[1]), .TICK(tick[1]), .FRAME(frame[1])
    );

    digit_scan_ctrl #(.DIV(8), .NUM_DIGITS(8), .BLANK_CYCLES(5)) u_c (
        .CLK(clk), .RST_N(rst_n), .EN(en[2]),
        .S0(s[2][0]), .S1(s[2][1]), .S2(s[2][2]),
        .AN(an[2]), .TICK(tick[2]), .FRAME(frame[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int m_dig(int i);
        return (d0[i] + k[i] / DIVS[i]) % NS[i];
    endfunction

    function automatic logic [7:0] m_an(int i);
        if (k[i] > 0 && (k[i] % DIVS[i]) >= BS[i])
            return ~(8'b1 << m_dig(i));
        return 8'hFF;
    endfunction

    function automatic logic m_tick(int i);
        return k[i] > 0 && (k[i] % DIVS[i]) == 0;
    endfunction

    function automatic logic m_frame(int i);
        return m_tick(i) && m_dig(i) == 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                k[i]  <= 0;
                d0[i] <= 0;
            end else if (en[i]) begin
                k[i]  <= k[i] + 1;
            end else begin
                d0[i] <= m_dig(i);
                k[i]  <= 0;
            end
        end
    end

    task automatic test_reset;
        rst_n = 1'b0;
        en    = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (s[i] !== 3'd0 || an[i] !== 8'hFF ||
                tick[i] !== 1'b0 || frame[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset inst%0d: s=%0d an=%h t=%b f=%b want 0 ff 0 0",
                         i, s[i], an[i], tick[i], frame[i]);
            end
        end
    endtask

    task automatic test_startup;
        @(negedge clk);
        en[0] = 1'b1;
        rst_n = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            @(posedge clk);
            #1;
            checks++;
            if (s[0] !== 3'(m_dig(0)) || an[0] !== m_an(0) ||
                tick[0] !== m_tick(0) || frame[0] !== m_frame(0)) begin
                errors++;
                $display("FAIL startup_model e%0d: s=%0d an=%h t=%b f=%b want %0d %h %b %b",
                         e, s[0], an[0], tick[0], frame[0],
                         m_dig(0), m_an(0), m_tick(0), m_frame(0));
            end
            if (e == 1) begin
                checks++;
                if (an[0] !== 8'hFE || s[0] !== 3'd0) begin
                    errors++;
                    $display("FAIL startup_e1: an=%h s=%0d want fe 0", an[0], s[0]);
                end
            end
            if (e == 4) begin
                checks++;
                if (s[0] !== 3'd1 || an[0] !== 8'hFF || tick[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL startup_e4: s=%0d an=%h t=%b want 1 ff 1",
                             s[0], an[0], tick[0]);
                end
            end
            if (e == 5) begin
                checks++;
                if (an[0] !== 8'hFD || tick[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL startup_e5: an=%h t=%b want fd 0", an[0], tick[0]);
                end
            end
        end
    endtask

    task automatic test_wrap;
        int last_frame;
        int nframes;
        last_frame = -1;
        nframes    = 0;
        for (int e = 0; e < 50; e++) begin
            @(posedge clk);
            #1;
            checks++;
            if (s[0] !== 3'(m_dig(0)) || an[0] !== m_an(0) ||
                tick[0] !== m_tick(0) || frame[0] !== m_frame(0)) begin
                errors++;
                $display("FAIL wrap_model: s=%0d an=%h t=%b f=%b want %0d %h %b %b",
                         s[0], an[0], tick[0], frame[0],
                         m_dig(0), m_an(0), m_tick(0), m_frame(0));
            end
            if (an[0][7:6] !== 2'b11) begin
                errors++;
                $display("FAIL wrap_unused_an: an=%h want bits 7:6 high", an[0]);
            end
            if (frame[0] === 1'b1) begin
                nframes++;
                checks++;
                if (s[0] !== 3'd0 || tick[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL wrap_frame: s=%0d t=%b want 0 1", s[0], tick[0]);
                end
                if (last_frame >= 0) begin
                    checks++;
                    if (e - last_frame != 24) begin
                        errors++;
                        $display("FAIL frame_period: got %0d want 24", e - last_frame);
                    end
                end
                last_frame = e;
            end
        end
        checks++;
        if (nframes != 2) begin
            errors++;
            $display("FAIL frame_count: got %0d want 2", nframes);
        end
    endtask

    task automatic test_enable_gating;
        logic found;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(posedge clk);
            #1;
            if (s[0] === 3'd2) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL gate_wait: s never reached 2");
        end
        en[0] = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk);
            #1;
            checks++;
            if (an[0] !== 8'hFF || s[0] !== 3'd2 || tick[0] !== 1'b0) begin
                errors++;
                $display("FAIL gate_off e%0d: an=%h s=%0d t=%b want ff 2 0",
                         e, an[0], s[0], tick[0]);
            end
        end
        en[0] = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk);
            #1;
            checks++;
            if (e == 1 && an[0] !== 8'hFB) begin
                errors++;
                $display("FAIL gate_on_an: an=%h want fb", an[0]);
            end
            if (e < 4 && s[0] !== 3'd2) begin
                errors++;
                $display("FAIL gate_on_hold e%0d: s=%0d want 2", e, s[0]);
            end
            if (e == 4 && (s[0] !== 3'd3 || tick[0] !== 1'b1)) begin
                errors++;
                $display("FAIL gate_on_adv: s=%0d t=%b want 3 1", s[0], tick[0]);
            end
        end
        for (int e = 0; e < 150; e++) begin
            @(posedge clk);
            #1;
            checks++;
            if (s[0] !== 3'(m_dig(0)) || an[0] !== m_an(0) ||
                tick[0] !== m_tick(0) || frame[0] !== m_frame(0)) begin
                errors++;
                $display("FAIL gate_rand: en=%b s=%0d an=%h t=%b f=%b want %0d %h %b %b",
                         en[0], s[0], an[0], tick[0], frame[0],
                         m_dig(0), m_an(0), m_tick(0), m_frame(0));
            end
            en[0] = ($urandom_range(0, 3) != 0);
        end
        en[0] = 1'b1;
    endtask

    task automatic test_async_reset;
        logic found;
        found = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            @(posedge clk);
            #1;
            if (s[0] === 3'd5) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL areset_wait: s never reached 5");
        end
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (s[i] !== 3'd0 || an[i] !== 8'hFF ||
                tick[i] !== 1'b0 || frame[i] !== 1'b0) begin
                errors++;
                $display("FAIL areset inst%0d: s=%0d an=%h t=%b f=%b want 0 ff 0 0",
                         i, s[i], an[i], tick[i], frame[i]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 0; e < 12; e++) begin
            @(posedge clk);
            #1;
            checks++;
            if (s[0] !== 3'(m_dig(0)) || an[0] !== m_an(0) ||
                tick[0] !== m_tick(0) || frame[0] !== m_frame(0)) begin
                errors++;
                $display("FAIL areset_restart: s=%0d an=%h t=%b f=%b want %0d %h %b %b",
                         s[0], an[0], tick[0], frame[0],
                         m_dig(0), m_an(0), m_tick(0), m_frame(0));
            end
        end
    endtask

    task automatic test_no_blank;
        int nframes;
        nframes = 0;
        @(negedge clk);
        en[1] = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            checks++;
            if (s[1] !== 3'(m_dig(1)) || an[1] !== m_an(1) ||
                tick[1] !== m_tick(1) || frame[1] !== m_frame(1)) begin
                errors++;
                $display("FAIL noblank_model: s=%0d an=%h t=%b f=%b want %0d %h %b %b",
                         s[1], an[1], tick[1], frame[1],
                         m_dig(1), m_an(1), m_tick(1), m_frame(1));
            end
            if (an[1] === 8'hFF || an[1] !== ~(8'b1 << s[1])) begin
                errors++;
                $display("FAIL noblank_an: an=%h s=%0d", an[1], s[1]);
            end
            if (frame[1] === 1'b1) nframes++;
        end
        checks++;
        if (nframes != 2) begin
            errors++;
            $display("FAIL noblank_frames: got %0d want 2", nframes);
        end
        en[1] = 1'b0;
    endtask

    task automatic test_long_blank;
        int  blank_run;
        int  show_run;
        logic measuring;
        blank_run = 0;
        show_run  = 0;
        measuring = 1'b0;
        @(negedge clk);
        en[2] = 1'b1;
        for (int e = 1; e <= 70; e++) begin
            @(posedge clk);
            #1;
            checks++;
            if (s[2] !== 3'(m_dig(2)) || an[2] !== m_an(2) ||
                tick[2] !== m_tick(2) || frame[2] !== m_frame(2)) begin
                errors++;
                $display("FAIL longblank_model: s=%0d an=%h t=%b f=%b want %0d %h %b %b",
                         s[2], an[2], tick[2], frame[2],
                         m_dig(2), m_an(2), m_tick(2), m_frame(2));
            end
            if ($countones(~an[2]) > 1) begin
                errors++;
                $display("FAIL longblank_onehot: an=%h", an[2]);
            end
            if (tick[2] === 1'b1) begin
                if (measuring) begin
                    checks++;
                    if (show_run != 3) begin
                        errors++;
                        $display("FAIL show_len: got %0d want 3", show_run);
                    end
                end
                measuring = 1'b1;
                blank_run = 0;
                show_run  = 0;
            end
            if (measuring) begin
                if (an[2] === 8'hFF) begin
                    blank_run++;
                end else begin
                    if (show_run == 0) begin
                        checks++;
                        if (blank_run != 5) begin
                            errors++;
                            $display("FAIL blank_len: got %0d want 5", blank_run);
                        end
                    end
                    show_run++;
                end
            end
        end
        en[2] = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_startup();
        test_wrap();
        test_enable_gating();
        test_async_reset();
        test_no_blank();
        test_long_blank();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/digit_scan_ctrl.md
# digit_scan_ctrl

- Scan controller that drives the stopwatch's multiplexed 7-segment display.
- Generates the 3-bit digit select (S2..S0) for the 8:1 digit-bit multiplexers, plus the matching active-low digit anode enables.
- Paces the scan with a programmable prescaler and inserts a blanking interval after every digit change to suppress ghosting.
- Emits per-digit and per-frame strobes for downstream blink and brightness logic.

## Interface
Parameters:
- DIV, default 50000: prescaler terminal count, in clock cycles per digit slot. Requires DIV >= 2.
- NUM_DIGITS, default 8: number of digits scanned, 2..8.
- BLANK_CYCLES, default 4: cycles the anodes stay off at the start of each slot. Requires 0 <= BLANK_CYCLES < DIV.

Ports:
- CLK  input  1  system clock; all state changes on its rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- EN  input  1  scan enable; when low, the display is blanked and the scan is frozen.
- S0  output  1  digit select bit 0 (LSB), to the select inputs of the digit mux.
- S1  output  1  digit select bit 1.
- S2  output  1  digit select bit 2 (MSB).
- AN  output  8  active-low one-hot digit enable; bit i corresponds to digit i.
- TICK  output  1  one-cycle pulse, coincident with each digit advance.
- FRAME  output  1  one-cycle pulse, coincident with the advance that wraps to digit 0.

## Operation
- State: prescaler cnt (width clog2(DIV)) and digit index idx (3 bits). All outputs are registered.
- EN=1, cnt != DIV-1: cnt <= cnt+1; idx held.
- EN=1, cnt == DIV-1 (slot end):
  - cnt <= 0.
  - idx <= 0 if idx == NUM_DIGITS-1, else idx+1.
  - TICK <= 1.
  - FRAME <= 1 only if idx was NUM_DIGITS-1.
- EN=0: cnt <= 0; idx held; TICK <= 0; FRAME <= 0.
- {S2,S1,S0} always equals the registered idx.
- Display phases are derived from the next-state values cnt' and idx':
  - OFF (EN=0) or BLANK (cnt' < BLANK_CYCLES): AN <= 8'hFF.
  - SHOW (EN=1 and cnt' >= BLANK_CYCLES): AN <= ~(8'b1 << idx').
- AN bits for indices >= NUM_DIGITS stay 1 permanently.
- At most one AN bit is ever low. AN is never low for a digit other than the one currently selected by S.

## Timing
- Reset values, applied immediately and asynchronously: S2..S0 = 000, AN = 8'hFF, TICK = 0, FRAME = 0, cnt = 0, idx = 0.
- First edge with EN sampled high after reset or after an EN-low period:
  - cnt becomes 1.
  - AN goes active on that same edge if BLANK_CYCLES <= 1; otherwise it goes active once cnt reaches BLANK_CYCLES.
- Digit advance occurs on the edge where cnt == DIV-1 is sampled. On that edge:
  - S changes.
  - AN goes to FF, or directly to the new digit when BLANK_CYCLES = 0.
  - TICK goes high for exactly one cycle.
- Blanking: AN stays FF for exactly BLANK_CYCLES cycles from the edge where S changes, then shows the new digit. S never changes while any AN bit is low, except when BLANK_CYCLES = 0.
- Slot period: DIV cycles. Frame period: DIV*NUM_DIGITS cycles. FRAME and TICK rise on the same edge.
- EN falling: on the next edge AN = FF, TICK = 0, S held. No advance occurs while EN = 0, even if cnt was DIV-1.
- EN rising: the next advance comes exactly DIV edges after the first EN-high edge. The held idx is shown again after blanking.
- Reset asserted mid-slot or mid-blank: all outputs go to reset values without waiting for CLK. After release, the scan restarts at digit 0.

## Test plan
- Reset/startup (DIV=4, NUM_DIGITS=6, BLANK_CYCLES=1): RST_N low -> S=000, AN=FF, TICK=FRAME=0. Release with EN=1 -> edge 1: AN=FE. Edge 4: S=001, AN=FF, TICK=1. Edge 5: AN=FD, TICK=0.
- Wrap (same parameters): S sequence 0..5 then 000. S returns to 000 at edge 24, with FRAME=1 and TICK=1 there. FRAME pulses once per 24 cycles; AN never goes low for digits 6 and 7.
- Enable gating (same parameters):
  - Drop EN for 3 cycles at idx=2 -> AN=FF one edge later; S held at 010; no TICK.
  - Raise EN -> AN=FB after 1 edge; S=011 exactly 4 edges after EN is first sampled high.
- Async reset mid-scan (same parameters): assert RST_N at idx=5 between clock edges -> S=000, AN=FF, TICK=FRAME=0 immediately, with no clock edge.
- No blanking (DIV=2, NUM_DIGITS=8, BLANK_CYCLES=0, EN=1): AN steps FE, FD, FB, ..., 7F, changing every 2 cycles on the same edge as S. AN is never FF after the first edge. S wraps from 111 to 000 with FRAME=1.
- Long blank (DIV=8, BLANK_CYCLES=5): after each advance, AN=FF for exactly 5 cycles, then active for 3 cycles.
